mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RISC-V pipeline, directly downstream of the EX/MEM register. It consumes the registered ALU result, opcode, funct3, rd and rs2 data, and runs loads and stores on a single-outstanding req/gnt/rvalid data bus. It sign- or zero-extends load data and presents a registered writeback bundle to the MEM/WB side. It stalls upstream while a bus access is in flight.

## Interface
- TIMEOUT_CYCLES, 255: cycles spent in REQ+WAIT before a bus access is aborted with an error (range 2..65535).
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- valid_i  input  1  EX/MEM holds a valid instruction.
- alu_out_i  input  32  effective address for load/store; result for other ops.
- opcode_i  input  7  instruction opcode.
- funct3_i  input  3  access size/sign.
- rd_i  input  5  destination register.
- rs2_data_i  input  32  store data.
- stall_o  output  1  hold EX/MEM and earlier stages (combinational).
- dbus_req_o  output  1  bus request, registered.
- dbus_we_o  output  1  1 = store.
- dbus_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}).
- dbus_be_o  output  4  byte enables.
- dbus_wdata_o  output  32  lane-replicated store data.
- dbus_gnt_i  input  1  request accepted.
- dbus_rvalid_i  input  1  load data valid.
- dbus_rdata_i  input  32  load data.
- wb_valid_o  output  1  writeback bundle valid, one-cycle pulse.
- wb_we_o  output  1  register-file write enable.
- wb_rd_o  output  5  writeback register.
- wb_data_o  output  32  writeback data.
- err_o  output  1  access error pulse, coincident with wb_valid_o.
- err_addr_o  output  32  full byte address of the faulting access.

## Operation
- LOAD = 7'b0000011, STORE = 7'b0100011. Everything else is non-memory.
- States: IDLE, REQ, WAIT, DONE. All outputs reset to 0; state resets to IDLE.
- IDLE, valid_i, non-memory op: register wb_data_o = alu_out_i, wb_rd_o = rd_i, wb_valid_o = 1. wb_we_o = (rd_i != 0) and opcode is not BRANCH (1100011). No stall.
- IDLE, valid_i, memory op: latch all fields and drive stall_o = 1. Go to REQ.
- REQ: dbus_req_o = 1, stall_o = 1. Hold addr/we/be/wdata stable until gnt. On gnt: a store goes to DONE; a load goes to WAIT. rvalid in REQ is ignored.
- WAIT: stall_o = 1. On rvalid, capture the formatted data and go to DONE.
- DONE: wb_valid_o = 1 and stall_o = 0. valid_i is ignored, because it is the same instruction. Next state is IDLE.
- Store bundle: wb_we_o = 0. Load bundle: wb_we_o = (rd != 0).
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1],1'b0}.
  - SW: 4'b1111.
- Store data: SB = {4{rs2[7:0]}}, SH = {2{rs2[15:0]}}, SW = rs2.
- Load formatting, selecting the lane by addr[1:0]:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes through.
  - Unlisted funct3 is treated as word size (LW/SW).
- Timeout: the counter clears on entry to REQ and increments each cycle in REQ/WAIT. If it reaches TIMEOUT_CYCLES-1 without completion, go to DONE with err_o = 1, wb_we_o = 0 and dbus_req_o dropped.
- Completion and timeout in the same cycle: completion wins, no error.
- Reset mid-access: immediate return to IDLE. dbus_req_o, stall_o and wb_valid_o go to 0 asynchronously.

## Timing
- Non-memory op: accepted at cycle T, wb_valid_o at T+1.
- Store, zero-wait gnt: accept at T, req at T+1, gnt at T+1, DONE/wb_valid_o at T+2. The upstream advances at the end of T+2.
- Load, zero-wait: req at T+1, gnt at T+1, rvalid at T+2, wb_valid_o at T+3.
- Each extra gnt or rvalid wait cycle adds one cycle.
- stall_o is high from T through the cycle before DONE.

## Configuration
- MISALIGN_TRAP_EN defined: a misaligned access never issues a bus request. Misaligned means LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0. The access goes IDLE→DONE, with err_o = 1, err_addr_o = address and wb_we_o = 0. Latency is wb_valid_o at T+1, with stall_o high at T.
- MISALIGN_TRAP_EN undefined: misalignment is never flagged. Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. err_o is raised only by timeout.

## Test plan
- Non-memory ADD result 0x1234, rd=5 at T -> wb_valid_o at T+1, wb_data_o = 0x00001234, wb_we_o = 1, stall_o never high.
- SB rs2 = 0x000000A5, addr 0x103, gnt after 2 wait cycles -> be = 4'b1000, wdata = 0xA5A5A5A5, addr = 0x100, wb_valid_o at T+4, wb_we_o = 0.
- LB addr 0x202, rdata 0x00800000, rd=7 -> wb_data_o = 0xFFFFFF80; the same access as LBU -> 0x00000080.
- LW with gnt never asserted, TIMEOUT_CYCLES = 4 -> err_o and wb_valid_o at T+5, err_addr_o = addr, req dropped, wb_we_o = 0.
- LH addr 0x301, with the macro defined -> no dbus_req_o, err_o at T+1. Without the macro -> bus access at 0x300, be = 4'b0011.
- rst_n low while in WAIT -> req, stall and wb_valid go to 0 immediately. After release, the next valid non-memory op completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage behind the EX/MEM register.
// Runs one load or store at a time on a req/gnt/rvalid data bus.
// Load data is formatted by size and sign, and a registered writeback bundle is produced.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses trap without using the bus.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] alu_out_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] rs2_data_i,
    output logic        stall_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    localparam logic [6:0]  OP_LOAD      = 7'b0000011;
    localparam logic [6:0]  OP_STORE     = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    state_e      state_q, state_d;
    logic [31:0] accAddr_q, accAddr_d;
    logic        accWe_q, accWe_d;
    logic [2:0]  accFunct3_q, accFunct3_d;
    logic [4:0]  accRd_q, accRd_d;
    logic [31:0] accWdata_q, accWdata_d;
    logic [3:0]  accBe_q, accBe_d;
    logic [15:0] timeoutCnt_q, timeoutCnt_d;
    logic        req_q, req_d;
    logic        wbValid_q, wbValid_d;
    logic        wbWe_q, wbWe_d;
    logic [4:0]  wbRd_q, wbRd_d;
    logic [31:0] wbData_q, wbData_d;
    logic        err_q, err_d;
    logic [31:0] errAddr_q, errAddr_d;

    size_e       sizeIn;
    logic [3:0]  beIn;
    logic [31:0] wdataIn;
    logic [31:0] loadData;
    logic        isMemOp;
    logic        misTrap;
    logic        stallRaw;

    assign isMemOp = (opcode_i == OP_LOAD) || (opcode_i == OP_STORE);

    // Decode access size; stores only know SB/SH, loads also have unsigned byte/half forms
    always_comb begin
        sizeIn = SZ_WORD;
        if (opcode_i == OP_STORE) begin
            if (funct3_i == 3'b000) sizeIn = SZ_BYTE;
            else if (funct3_i == 3'b001) sizeIn = SZ_HALF;
        end else begin
            if (funct3_i[1:0] == 2'b00) sizeIn = SZ_BYTE;
            else if (funct3_i[1:0] == 2'b01) sizeIn = SZ_HALF;
        end
    end

    // Build byte enables and lane-replicated store data for the incoming access
    always_comb begin
        beIn    = 4'b1111;
        wdataIn = rs2_data_i;
        case (sizeIn)
            SZ_BYTE: begin
                beIn    = 4'b0001 << alu_out_i[1:0];
                wdataIn = {4{rs2_data_i[7:0]}};
            end
            SZ_HALF: begin
                beIn    = 4'b0011 << {alu_out_i[1], 1'b0};
                wdataIn = {2{rs2_data_i[15:0]}};
            end
            default: begin
                beIn    = 4'b1111;
                wdataIn = rs2_data_i;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Flag halfword and word accesses that are not naturally aligned
    always_comb begin
        misTrap = 1'b0;
        if (sizeIn == SZ_HALF) misTrap = alu_out_i[0];
        else if (sizeIn == SZ_WORD) misTrap = (alu_out_i[1:0] != 2'b00);
    end
`else
    assign misTrap = 1'b0;
`endif

    // Pick the addressed lane of the returned word and sign- or zero-extend it
    always_comb begin
        loadData = dbus_rdata_i;
        case (accFunct3_q)
            3'b000: loadData = {{24{dbus_rdata_i[{accAddr_q[1:0], 3'b111}]}},
                                dbus_rdata_i[{accAddr_q[1:0], 3'b000} +: 8]};
            3'b100: loadData = {24'd0, dbus_rdata_i[{accAddr_q[1:0], 3'b000} +: 8]};
            3'b001: loadData = {{16{dbus_rdata_i[{accAddr_q[1], 4'b1111}]}},
                                dbus_rdata_i[{accAddr_q[1], 4'b0000} +: 16]};
            3'b101: loadData = {16'd0, dbus_rdata_i[{accAddr_q[1], 4'b0000} +: 16]};
            default: loadData = dbus_rdata_i;
        endcase
    end

    // Access sequencing: accept, request, wait for data, then emit the writeback bundle
    always_comb begin
        state_d      = state_q;
        accAddr_d    = accAddr_q;
        accWe_d      = accWe_q;
        accFunct3_d  = accFunct3_q;
        accRd_d      = accRd_q;
        accWdata_d   = accWdata_q;
        accBe_d      = accBe_q;
        timeoutCnt_d = timeoutCnt_q;
        req_d        = 1'b0;
        wbValid_d    = 1'b0;
        wbWe_d       = wbWe_q;
        wbRd_d       = wbRd_q;
        wbData_d     = wbData_q;
        err_d        = 1'b0;
        errAddr_d    = errAddr_q;
        stallRaw     = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && isMemOp) begin
                    stallRaw    = 1'b1;
                    accAddr_d   = alu_out_i;
                    accWe_d     = (opcode_i == OP_STORE);
                    accFunct3_d = funct3_i;
                    accRd_d     = rd_i;
                    accWdata_d  = wdataIn;
                    accBe_d     = beIn;
                    if (misTrap) begin
                        state_d   = DONE;
                        wbValid_d = 1'b1;
                        wbWe_d    = 1'b0;
                        wbRd_d    = rd_i;
                        wbData_d  = 32'd0;
                        err_d     = 1'b1;
                        errAddr_d = alu_out_i;
                    end else begin
                        state_d      = REQ;
                        req_d        = 1'b1;
                        timeoutCnt_d = 16'd0;
                    end
                end else if (valid_i) begin
                    wbValid_d = 1'b1;
                    wbData_d  = alu_out_i;
                    wbRd_d    = rd_i;
                    wbWe_d    = (rd_i != 5'd0) && (opcode_i != OP_BRANCH);
                end
            end
            REQ: begin
                stallRaw     = 1'b1;
                timeoutCnt_d = timeoutCnt_q + 16'd1;
                if (dbus_gnt_i) begin
                    if (accWe_q) begin
                        state_d   = DONE;
                        wbValid_d = 1'b1;
                        wbWe_d    = 1'b0;
                        wbRd_d    = accRd_q;
                        wbData_d  = 32'd0;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeoutCnt_q == TIMEOUT_LAST) begin
                    state_d   = DONE;
                    wbValid_d = 1'b1;
                    wbWe_d    = 1'b0;
                    wbRd_d    = accRd_q;
                    wbData_d  = 32'd0;
                    err_d     = 1'b1;
                    errAddr_d = accAddr_q;
                end else begin
                    req_d = 1'b1;
                end
            end
            WAIT: begin
                stallRaw     = 1'b1;
                timeoutCnt_d = timeoutCnt_q + 16'd1;
                if (dbus_rvalid_i) begin
                    state_d   = DONE;
                    wbValid_d = 1'b1;
                    wbWe_d    = (accRd_q != 5'd0);
                    wbRd_d    = accRd_q;
                    wbData_d  = loadData;
                end else if (timeoutCnt_q == TIMEOUT_LAST) begin
                    state_d   = DONE;
                    wbValid_d = 1'b1;
                    wbWe_d    = 1'b0;
                    wbRd_d    = accRd_q;
                    wbData_d  = 32'd0;
                    err_d     = 1'b1;
                    errAddr_d = accAddr_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            accAddr_q    <= 32'd0;
            accWe_q      <= 1'b0;
            accFunct3_q  <= 3'd0;
            accRd_q      <= 5'd0;
            accWdata_q   <= 32'd0;
            accBe_q      <= 4'd0;
            timeoutCnt_q <= 16'd0;
            req_q        <= 1'b0;
            wbValid_q    <= 1'b0;
            wbWe_q       <= 1'b0;
            wbRd_q       <= 5'd0;
            wbData_q     <= 32'd0;
            err_q        <= 1'b0;
            errAddr_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            accAddr_q    <= accAddr_d;
            accWe_q      <= accWe_d;
            accFunct3_q  <= accFunct3_d;
            accRd_q      <= accRd_d;
            accWdata_q   <= accWdata_d;
            accBe_q      <= accBe_d;
            timeoutCnt_q <= timeoutCnt_d;
            req_q        <= req_d;
            wbValid_q    <= wbValid_d;
            wbWe_q       <= wbWe_d;
            wbRd_q       <= wbRd_d;
            wbData_q     <= wbData_d;
            err_q        <= err_d;
            errAddr_q    <= errAddr_d;
        end
    end

    assign stall_o      = stallRaw & rst_n;
    assign dbus_req_o   = req_q;
    assign dbus_we_o    = accWe_q;
    assign dbus_addr_o  = {accAddr_q[31:2], 2'b00};
    assign dbus_be_o    = accBe_q;
    assign dbus_wdata_o = accWdata_q;
    assign wb_valid_o   = wbValid_q;
    assign wb_we_o      = wbWe_q;
    assign wb_rd_o      = wbRd_q;
    assign wb_data_o    = wbData_q;
    assign err_o        = err_q;
    assign err_addr_o   = errAddr_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with a four-cycle timeout.
// Expected values are hand-computed from the stage's documented behaviour.
module tb_mem_stage;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] alu_out_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic [31:0] rs2_data_i;
    logic        stall_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;
    logic [31:0] err_addr_o;

    int passCount  = 0;
    int checkCount = 0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .alu_out_i    (alu_out_i),
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .rd_i         (rd_i),
        .rs2_data_i   (rs2_data_i),
        .stall_o      (stall_o),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_be_o    (dbus_be_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_gnt_i   (dbus_gnt_i),
        .dbus_rvalid_i(dbus_rvalid_i),
        .dbus_rdata_i (dbus_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_we_o      (wb_we_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .err_o        (err_o),
        .err_addr_o   (err_addr_o)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] rs2);
        valid_i    = v;
        alu_out_i  = alu;
        opcode_i   = op;
        funct3_i   = f3;
        rd_i       = rd;
        rs2_data_i = rs2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic runZeroWaitLoad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                                   input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] expData);
        applyStimulus(1'b1, addr, OP_LOAD, f3, rd, 32'd0);
        nextCycle();
        checkOutput({tag, "_req"}, 32'(dbus_req_o), 32'd1);
        dbus_gnt_i = 1'b1;
        nextCycle();
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = rdata;
        nextCycle();
        dbus_rvalid_i = 1'b0;
        checkOutput({tag, "_valid"}, 32'(wb_valid_o), 32'd1);
        checkOutput({tag, "_data"}, wb_data_o, expData);
        checkOutput({tag, "_we"}, 32'(wb_we_o), (rd != 5'd0) ? 32'd1 : 32'd0);
        applyStimulus(1'b0, 32'd0, 7'd0, 3'd0, 5'd0, 32'd0);
        nextCycle();
    endtask

    initial begin
        rst_n         = 1'b0;
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = 32'd0;
        applyStimulus(1'b0, 32'd0, 7'd0, 3'd0, 5'd0, 32'd0);
        #3;
        checkOutput("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        checkOutput("rst_req", 32'(dbus_req_o), 32'd0);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        checkOutput("rst_wb_data", wb_data_o, 32'd0);
        #9 rst_n = 1'b1;
        nextCycle();

        $display("[TB] non-memory ops");
        applyStimulus(1'b1, 32'h1234, OP_ALU, 3'd0, 5'd5, 32'd0);
        #1 checkOutput("add_stall_T", 32'(stall_o), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 32'h55, OP_BRANCH, 3'd0, 5'd3, 32'd0);
        checkOutput("add_valid", 32'(wb_valid_o), 32'd1);
        checkOutput("add_data", wb_data_o, 32'h00001234);
        checkOutput("add_we", 32'(wb_we_o), 32'd1);
        checkOutput("add_rd", 32'(wb_rd_o), 32'd5);
        checkOutput("add_stall_T1", 32'(stall_o), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 32'h77, OP_ALU, 3'd0, 5'd0, 32'd0);
        checkOutput("branch_we", 32'(wb_we_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 7'd0, 3'd0, 5'd0, 32'd0);
        checkOutput("x0_we", 32'(wb_we_o), 32'd0);
        checkOutput("x0_valid", 32'(wb_valid_o), 32'd1);
        nextCycle();
        checkOutput("idle_valid", 32'(wb_valid_o), 32'd0);

        $display("[TB] SB with two gnt wait cycles");
        applyStimulus(1'b1, 32'h103, OP_STORE, 3'b000, 5'd0, 32'h000000A5);
        #1 checkOutput("sb_stall_T", 32'(stall_o), 32'd1);
        nextCycle();
        checkOutput("sb_req", 32'(dbus_req_o), 32'd1);
        checkOutput("sb_we", 32'(dbus_we_o), 32'd1);
        checkOutput("sb_be", 32'(dbus_be_o), 32'h8);
        checkOutput("sb_wdata", dbus_wdata_o, 32'hA5A5A5A5);
        checkOutput("sb_addr", dbus_addr_o, 32'h00000100);
        nextCycle();
        checkOutput("sb_req_hold", 32'(dbus_req_o), 32'd1);
        nextCycle();
        checkOutput("sb_stall_T3", 32'(stall_o), 32'd1);
        dbus_gnt_i = 1'b1;
        nextCycle();
        dbus_gnt_i = 1'b0;
        checkOutput("sb_wb_valid", 32'(wb_valid_o), 32'd1);
        checkOutput("sb_wb_we", 32'(wb_we_o), 32'd0);
        checkOutput("sb_stall_done", 32'(stall_o), 32'd0);
        checkOutput("sb_req_drop", 32'(dbus_req_o), 32'd0);
        applyStimulus(1'b0, 32'd0, 7'd0, 3'd0, 5'd0, 32'd0);
        nextCycle();
        checkOutput("sb_pulse", 32'(wb_valid_o), 32'd0);

        $display("[TB] SH zero-wait");
        applyStimulus(1'b1, 32'h102, OP_STORE, 3'b001, 5'd0, 32'h1234BEEF);
        nextCycle();
        checkOutput("sh_be", 32'(dbus_be_o), 32'hC);
        checkOutput("sh_wdata", dbus_wdata_o, 32'hBEEFBEEF);
        dbus_gnt_i = 1'b1;
        nextCycle();
        dbus_gnt_i = 1'b0;
        checkOutput("sh_wb_valid", 32'(wb_valid_o), 32'd1);
        applyStimulus(1'b0, 32'd0, 7'd0, 3'd0, 5'd0, 32'd0);
        nextCycle();

        $display("[TB] load formatting");
        runZeroWaitLoad("lb", 32'h202, 3'b000, 5'd7, 32'h00800000, 32'hFFFFFF80);
        runZeroWaitLoad("lbu", 32'h202, 3'b100, 5'd7, 32'h00800000, 32'h00000080);
        runZeroWaitLoad("lh", 32'h302, 3'b001, 5'd8, 32'h80011234, 32'hFFFF8001);
        runZeroWaitLoad("lhu", 32'h302, 3'b101, 5'd8, 32'h80011234, 32'h00008001);
        runZeroWaitLoad("lw_x0", 32'h400, 3'b010, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF);

        $display("[TB] LW timeout");
        applyStimulus(1'b1, 32'h404, OP_LOAD, 3'b010, 5'd9, 32'd0);
        nextCycle();
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("to_req_T4", 32'(dbus_req_o), 32'd1);
        checkOutput("to_valid_T4", 32'(wb_valid_o), 32'd0);
        nextCycle();
        checkOutput("to_valid", 32'(wb_valid_o), 32'd1);
        checkOutput("to_err", 32'(err_o), 32'd1);
        checkOutput("to_err_addr", err_addr_o, 32'h00000404);
        checkOutput("to_req_drop", 32'(dbus_req_o), 32'd0);
        checkOutput("to_we", 32'(wb_we_o), 32'd0);
        applyStimulus(1'b0, 32'd0, 7'd0, 3'd0, 5'd0, 32'd0);
        nextCycle();
        checkOutput("to_err_pulse", 32'(err_o), 32'd0);

        $display("[TB] SW granted on the last timeout cycle");
        applyStimulus(1'b1, 32'h600, OP_STORE, 3'b010, 5'd0, 32'h11223344);
        nextCycle();
        checkOutput("sw_be", 32'(dbus_be_o), 32'hF);
        checkOutput("sw_wdata", dbus_wdata_o, 32'h11223344);
        nextCycle();
        nextCycle();
        nextCycle();
        dbus_gnt_i = 1'b1;
        nextCycle();
        dbus_gnt_i = 1'b0;
        checkOutput("sw_late_valid", 32'(wb_valid_o), 32'd1);
        checkOutput("sw_late_err", 32'(err_o), 32'd0);
        applyStimulus(1'b0, 32'd0, 7'd0, 3'd0, 5'd0, 32'd0);
        nextCycle();

        $display("[TB] LH at odd address");
        applyStimulus(1'b1, 32'h301, OP_LOAD, 3'b001, 5'd4, 32'd0);
        #1 checkOutput("mis_stall_T", 32'(stall_o), 32'd1);
        nextCycle();
`ifdef MISALIGN_TRAP_EN
        checkOutput("mis_req", 32'(dbus_req_o), 32'd0);
        checkOutput("mis_valid", 32'(wb_valid_o), 32'd1);
        checkOutput("mis_err", 32'(err_o), 32'd1);
        checkOutput("mis_err_addr", err_addr_o, 32'h00000301);
        checkOutput("mis_we", 32'(wb_we_o), 32'd0);
`else
        checkOutput("lh301_req", 32'(dbus_req_o), 32'd1);
        checkOutput("lh301_addr", dbus_addr_o, 32'h00000300);
        checkOutput("lh301_be", 32'(dbus_be_o), 32'h3);
        dbus_gnt_i = 1'b1;
        nextCycle();
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 32'h1234ABCD;
        nextCycle();
        dbus_rvalid_i = 1'b0;
        checkOutput("lh301_data", wb_data_o, 32'hFFFFABCD);
        checkOutput("lh301_err", 32'(err_o), 32'd0);
`endif
        applyStimulus(1'b0, 32'd0, 7'd0, 3'd0, 5'd0, 32'd0);
        nextCycle();

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, 32'h500, OP_LOAD, 3'b010, 5'd2, 32'd0);
        nextCycle();
        dbus_gnt_i = 1'b1;
        nextCycle();
        dbus_gnt_i = 1'b0;
        checkOutput("wait_stall", 32'(stall_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_stall", 32'(stall_o), 32'd0);
        checkOutput("arst_req", 32'(dbus_req_o), 32'd0);
        checkOutput("arst_wb_valid", 32'(wb_valid_o), 32'd0);
        applyStimulus(1'b0, 32'd0, 7'd0, 3'd0, 5'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(1'b1, 32'hCAFE, OP_ALU, 3'd0, 5'd6, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 7'd0, 3'd0, 5'd0, 32'd0);
        checkOutput("post_rst_valid", 32'(wb_valid_o), 32'd1);
        checkOutput("post_rst_data", wb_data_o, 32'h0000CAFE);
        checkOutput("post_rst_rd", 32'(wb_rd_o), 32'd6);
        nextCycle();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
